// File: rtl/encoder_pkg.sv
// Shared widths and FSM state encoding for the 4-to-2 capture encoder.
package encoder_pkg;

   localparam int unsigned IN_W   = 4;
   localparam int unsigned CODE_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/priority_encode4.sv
// Combinational 4-input priority encoder; PRIORITY_HIGH picks highest (1) or lowest (0) set bit.
module priority_encode4
   import encoder_pkg::*;
#(
   parameter bit PRIORITY_HIGH = 1'b1
) (
   input  logic [IN_W-1:0]   d,
   output logic [CODE_W-1:0] idx_c
);

   // Later matches overwrite earlier ones, so scan order decides the winner.
   always_comb begin
      idx_c = '0;
      if (PRIORITY_HIGH) begin
         for (int i = 0; i < int'(IN_W); i++) begin
            if (d[i]) idx_c = CODE_W'(i);
         end
      end else begin
         for (int i = int'(IN_W) - 1; i >= 0; i--) begin
            if (d[i]) idx_c = CODE_W'(i);
         end
      end
   end

endmodule

// File: rtl/encoder4to2_with_enable.sv
// Capturing 4-to-2 encoder with valid/ready hold. Define ENCODER_ONEHOT_CHECK_EN
// to register a multi-bit flag (o_multi) with each captured code; otherwise o_multi is 0.
module encoder4to2_with_enable
   import encoder_pkg::*;
#(
   parameter bit PRIORITY_HIGH = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [IN_W-1:0]   d,
   input  logic              o_ready,
   output logic [CODE_W-1:0] o,
   output logic              o_valid,
   output logic              o_multi
);

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   o_q, o_d;
   logic                o_valid_q, o_valid_d;
   logic [CODE_W-1:0]   idx_c;
   logic                capture_c;
   logic                load_c;

   priority_encode4 #(
      .PRIORITY_HIGH (PRIORITY_HIGH)
   ) u_enc (
      .d     (d),
      .idx_c (idx_c)
   );

   assign capture_c = en && (d != '0);

   // Next-state: a capture is taken in IDLE, or in HOLD once the held code is accepted.
   always_comb begin
      state_d   = state_q;
      o_d       = o_q;
      o_valid_d = o_valid_q;
      load_c    = 1'b0;
      case (state_q)
         IDLE: begin
            o_valid_d = 1'b0;
            if (capture_c) begin
               load_c    = 1'b1;
               o_valid_d = 1'b1;
               state_d   = HOLD;
            end
         end
         HOLD: begin
            if (o_ready) begin
               if (capture_c) begin
                  load_c    = 1'b1;
                  o_valid_d = 1'b1;
               end else begin
                  o_valid_d = 1'b0;
                  state_d   = IDLE;
               end
            end
         end
         default: begin
            o_valid_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
      if (load_c) o_d = idx_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         o_q       <= '0;
         o_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         o_q       <= o_d;
         o_valid_q <= o_valid_d;
      end
   end

   assign o       = o_q;
   assign o_valid = o_valid_q;

`ifdef ENCODER_ONEHOT_CHECK_EN
   logic multi_c;
   logic o_multi_q, o_multi_d;

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign multi_c = (d & (d - IN_W'(1))) != '0;

   always_comb begin
      o_multi_d = o_multi_q;
      if (load_c) o_multi_d = multi_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) o_multi_q <= 1'b0;
      else        o_multi_q <= o_multi_d;
   end

   assign o_multi = o_multi_q;
`else
   assign o_multi = 1'b0;
`endif

endmodule

// File: tb/tb_encoder4to2_with_enable.sv
// Bench for encoder4to2_with_enable: both priority settings side by side, behavioural
// model checked every cycle plus directed literal checks.
module tb_encoder4to2_with_enable;

`ifdef ENCODER_ONEHOT_CHECK_EN
   localparam bit MULTI_ON = 1'b1;
`else
   localparam bit MULTI_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] d = 4'b0000;
   logic       o_ready = 1'b0;

   logic [1:0] o_hi, o_lo;
   logic       v_hi, v_lo, m_hi, m_lo;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   encoder4to2_with_enable #(.PRIORITY_HIGH(1'b1)) u_hi (
      .clk(clk), .rst_n(rst_n), .en(en), .d(d), .o_ready(o_ready),
      .o(o_hi), .o_valid(v_hi), .o_multi(m_hi)
   );

   encoder4to2_with_enable #(.PRIORITY_HIGH(1'b0)) u_lo (
      .clk(clk), .rst_n(rst_n), .en(en), .d(d), .o_ready(o_ready),
      .o(o_lo), .o_valid(v_lo), .o_multi(m_lo)
   );

   // Index of the winning request: highest set bit, or lowest set bit.
   function automatic int enc(input logic [3:0] v, input bit high);
      int r;
      r = 0;
      if (high) begin
         for (int k = 3; k >= 0; k--) if (v[k]) begin r = k; break; end
      end else begin
         for (int k = 0; k < 4; k++) if (v[k]) begin r = k; break; end
      end
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a code is pending until accepted; a new sample may replace it only then.
   int m_o_hi = 0, m_o_lo = 0;
   bit m_valid = 0, m_multi = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_o_hi  <= 0;
         m_o_lo  <= 0;
         m_valid <= 0;
         m_multi <= 0;
      end else if (!m_valid || o_ready) begin
         if (en && d != 4'b0000) begin
            m_valid <= 1;
            m_o_hi  <= enc(d, 1'b1);
            m_o_lo  <= enc(d, 1'b0);
            m_multi <= MULTI_ON && ($countones(d) > 1);
         end else begin
            m_valid <= 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_o_hi",     int'(o_hi), m_o_hi);
      chk("cyc_o_lo",     int'(o_lo), m_o_lo);
      chk("cyc_valid_hi", int'(v_hi), int'(m_valid));
      chk("cyc_valid_lo", int'(v_lo), int'(m_valid));
      chk("cyc_multi_hi", int'(m_hi), int'(m_multi));
      chk("cyc_multi_lo", int'(m_lo), int'(m_multi));
   end

   task automatic step(input logic e, input logic [3:0] dv, input logic r);
      en      = e;
      d       = dv;
      o_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input int ohi, input int olo,
                             input int v, input int m);
      chk({name, "_o_hi"},  int'(o_hi), ohi);
      chk({name, "_o_lo"},  int'(o_lo), olo);
      chk({name, "_valid"}, int'(v_hi), v);
      chk({name, "_vlo"},   int'(v_lo), v);
      chk({name, "_multi"}, int'(m_hi), m);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 0, 0, 0, 0);
      #2 rst_n = 1'b1;

      // Disabled samples never capture
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'b0100, 1'b0);
         expect_out("en_off", 0, 0, 0, 0);
      end

      // Capture, hold while inputs move, then accept
      step(1'b1, 4'b0010, 1'b0);
      expect_out("cap_0010", 1, 1, 1, 0);
      step(1'b1, 4'b1000, 1'b0);
      expect_out("hold_1", 1, 1, 1, 0);
      step(1'b0, 4'b0000, 1'b0);
      expect_out("hold_2", 1, 1, 1, 0);
      step(1'b0, 4'b0000, 1'b1);
      expect_out("accept", 1, 1, 0, 0);

      // Multi-bit samples resolve per priority
      step(1'b1, 4'b1010, 1'b0);
      expect_out("multi_1010", 3, 1, 1, int'(MULTI_ON));
      step(1'b0, 4'b0000, 1'b1);
      step(1'b1, 4'b0110, 1'b1);
      expect_out("multi_0110", 2, 1, 1, int'(MULTI_ON));
      step(1'b0, 4'b0000, 1'b1);
      expect_out("drop", 2, 1, 0, 0);

      // Zero request with enable, and ready while idle
      step(1'b1, 4'b0000, 1'b1);
      expect_out("zero_req", 2, 1, 0, 0);

      // Back-to-back reload without a bubble
      step(1'b1, 4'b0001, 1'b0);
      expect_out("b2b_first", 0, 0, 1, 0);
      step(1'b1, 4'b1000, 1'b1);
      expect_out("b2b_second", 3, 3, 1, 0);

      // Single-bit sweep with continuous acceptance
      for (int i = 0; i < 4; i++) begin
         logic [3:0] one;
         one = 4'b0001 << i;
         step(1'b1, one, 1'b1);
         expect_out("sweep", i, i, 1, 0);
      end
      step(1'b0, 4'b0000, 1'b1);
      expect_out("sweep_end", 3, 3, 0, 0);

      // Asynchronous reset while holding a code
      step(1'b1, 4'b0100, 1'b0);
      expect_out("pre_reset", 2, 2, 1, 0);
      #2;
      rst_n = 1'b0;
      en    = 1'b0;
      d     = 4'b0000;
      #1;
      expect_out("async_rst", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      expect_out("in_rst", 0, 0, 0, 0);
      #2 rst_n = 1'b1;
      step(1'b1, 4'b0001, 1'b0);
      expect_out("post_rst", 0, 0, 1, 0);
      step(1'b0, 4'b0000, 1'b1);
      expect_out("post_rst_acc", 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/encoder4to2_with_enable.md
ENCODER4TO2_WITH_ENABLE -- requirements
Module: encoder4to2_with_enable

Interface
REQ-001 Parameter PRIORITY_HIGH, default 1, SHALL select the winning input: 1 = highest set index wins, 0 = lowest set index wins.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 en  input  1  SHALL be the capture enable; a sample is taken only when en=1.
REQ-005 d  input  4  SHALL be the request lines d[3:0], sampled when a capture occurs.
REQ-006 o_ready  input  1  SHALL be the consumer acceptance strobe.
REQ-007 o  output  2  SHALL be the registered encoded index of the captured sample.
REQ-008 o_valid  output  1  SHALL be high while o holds a code not yet accepted.
REQ-009 o_multi  output  1  SHALL flag that the captured sample had more than one bit set (see Configuration).

Function
REQ-010 The FSM SHALL have two states, IDLE and HOLD.
REQ-011 Capture condition SHALL be en=1 and d!=4'b0000, evaluated at the clock edge.
REQ-012 In IDLE with capture condition true, the block SHALL load o with the encoded index and enter HOLD; o_valid rises 1 cycle after the sampling edge (latency 1).
REQ-013 In IDLE with capture condition false, the block SHALL stay in IDLE with o_valid=0 and o unchanged.
REQ-014 In HOLD, o, o_multi and o_valid=1 SHALL remain stable until o_ready=1, regardless of en or d.
REQ-015 In HOLD with o_ready=1 and capture condition true, the block SHALL load the new code and stay in HOLD (back-to-back, no bubble cycle).
REQ-016 In HOLD with o_ready=1 and capture condition false, the block SHALL return to IDLE and drop o_valid the next cycle.
REQ-017 o_ready in IDLE SHALL be ignored.
REQ-018 d=4'b0000 with en=1 SHALL NOT produce a code; o_valid stays 0 in IDLE.
REQ-019 Encoding SHALL map single bit d[k] to o=k; multi-bit samples resolve per PRIORITY_HIGH (d=4'b1010 gives o=3 if PRIORITY_HIGH=1, o=1 if 0).

Reset
REQ-020 rst_n=0 SHALL immediately force state=IDLE, o=2'b00, o_valid=0, o_multi=0, independent of clk.
REQ-021 Reset asserted in HOLD SHALL discard the pending code; no acceptance is reported.
REQ-022 After rst_n deassertion the first capture SHALL obey REQ-012 unchanged.

Configuration
REQ-023 Macro ENCODER_ONEHOT_CHECK_EN defined: o_multi SHALL be registered with o at every capture, 1 when popcount(d)>1, held with o in HOLD.
REQ-024 Macro ENCODER_ONEHOT_CHECK_EN undefined: o_multi SHALL be tied to 0 and no popcount logic synthesised; all other behaviour identical.

Structure
REQ-025 Package encoder_pkg SHALL hold the state encoding (IDLE, HOLD), input width 4 and code width 2 constants.
REQ-026 Sub-module priority_encode4 (combinational, d + PRIORITY_HIGH -> index) SHALL hold the encode logic; the top holds FSM and output registers.

Verification
REQ-027 Reset then en=0, d=4'b0100 for 3 cycles -> o_valid=0, o=00 throughout.
REQ-028 en=1, d=4'b0010 one cycle, o_ready=0 -> next cycle o=01, o_valid=1, held while d changes; o_ready=1 -> o_valid=0 next cycle.
REQ-029 PRIORITY_HIGH=1, d=4'b1010 -> o=11, o_multi=1 (macro defined) / 0 (undefined); PRIORITY_HIGH=0 same stimulus -> o=01.
REQ-030 HOLD with o=00, o_ready=1, en=1, d=4'b1000 same edge -> o=11, o_valid stays 1 without gap.
REQ-031 HOLD with o=10, drop rst_n between edges -> o_valid=0, o=00 immediately; after release en=1, d=4'b0001 -> o=00, o_valid=1 one cycle later.
REQ-032 Sweep i1/i0 style: single-bit d=0001,0010,0100,1000 with en=1 and o_ready=1 each cycle -> o=00,01,10,11 on consecutive cycles, o_valid continuously 1.
